fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter PROG_LEN, default 16'd42: number of valid instruction-ROM words; PC equal to PROG_LEN ends the program.
REQ-002 Parameter BR_OPCODE, default 4'hB: opcode of the conditional branch (format=1).
REQ-003 Port list, one per line (name  direction  width  meaning); clock and reset first:
  clk  in  1  single clock; all state updates on the rising edge
  reset  in  1  asynchronous, active-high reset
  start  in  1  one-cycle pulse that launches a program run
  pc_in  out  16  fetch address driven to the instruction ROM (registered PC)
  instr_format  in  1  ROM format bit
  instr_opcode  in  4  ROM opcode field
  instr_sign  in  1  ROM sign field
  instr_operand  in  3  ROM operand field
  instr_immediate  in  8  ROM immediate field
  ex_valid  out  1  issue request to the datapath
  ex_ready  in  1  datapath accepts the issued instruction
  ex_format / ex_opcode / ex_sign / ex_operand / ex_immediate  out  1/4/1/3/8  latched IR fields presented with ex_valid
  branch_flag  in  1  datapath condition, sampled in BRANCH
  br_offset  in  16  signed PC displacement, sampled in BRANCH
  busy  out  1  high in FETCH, ISSUE and BRANCH
  halted  out  1  high in HALT
  instr_count  out  16  number of instructions accepted in the current run

Function
REQ-004 FSM states: IDLE, FETCH, ISSUE, BRANCH, HALT; reset state is IDLE.
REQ-005 IDLE or HALT with start=1: PC<=0, instr_count<=0, next state FETCH; start is ignored in every other state.
REQ-006 FETCH (1 cycle): if PC==PROG_LEN, go to HALT; otherwise latch all five ROM fields into the IR and go to ISSUE.
REQ-007 Halt instruction 9'b111111111 (format=1, opcode 4'hF, sign=1, operand 3'b111) latched in FETCH: go to HALT next cycle, never issued, instr_count unchanged.
REQ-008 ISSUE: ex_valid=1 and ex_* equal the IR; ex_valid and IR fields stay stable until the ex_ready cycle.
REQ-009 ISSUE with ex_ready=1: instr_count increments; if the IR is format=1 with opcode==BR_OPCODE, go to BRANCH; otherwise PC<=PC+1 and go to FETCH.
REQ-010 ISSUE with ex_ready=0: remain in ISSUE with no state change.
REQ-011 BRANCH (1 cycle, ex_valid=0): if branch_flag=1, PC<=PC+br_offset; otherwise PC<=PC+1; next state FETCH.
REQ-012 All PC arithmetic is modulo 2^16; 16'hFFFF+1 wraps to 0, and negative offsets are two's complement.
REQ-013 Minimum issue rate: one instruction per 2 cycles (FETCH, ISSUE) with ex_ready held at 1; a branch adds 1 cycle.
REQ-014 instr_count saturates at 16'hFFFF.
REQ-015 ex_valid is 0 in every state except ISSUE.
REQ-016 halted=1 only in HALT; busy=1 only in FETCH, ISSUE and BRANCH.

Reset
REQ-017 Asserting reset in any state, including mid-handshake, forces IDLE asynchronously: pc_in=0, IR=0, ex_valid=0, busy=0, halted=0, instr_count=0.
REQ-018 After reset deasserts, the FSM waits for start before fetching.

Structure
REQ-019 A shared package holds the state enumeration, the HALT_WORD constant 9'b111111111, BR_OPCODE and the field-width constants (opcode 4, operand 3, immediate 8, PC 16).
REQ-020 The PC register and its next-PC adder/wrap logic form one sub-module, pc_unit; the FSM, IR and counter stay in fetch_ctrl.

Verification
REQ-021 Straight-line run: 3 non-branch words followed by the halt word, ex_ready=1 -> pc_in sequence 0,1,2,3; instr_count=3; halted=1 on the cycle after FETCH at PC 3.
REQ-022 Backpressure: ex_ready=0 for 5 cycles in ISSUE -> ex_valid and ex_* held constant, PC unchanged, count increments once.
REQ-023 Branch taken at PC 10 with br_offset=16'hFFFB and flag=1 -> next fetch at PC 5; with flag=0 -> next fetch at PC 11.
REQ-024 Wrap: PC=16'hFFFF with a non-branch word, PROG_LEN=0 -> next PC 0, and FETCH at PC 0 enters HALT.
REQ-025 Reset asserted during ISSUE -> same-cycle ex_valid=0; IDLE with all outputs zero; start then restarts at PC 0.
REQ-026 start pulsed in ISSUE -> ignored; start in HALT -> new run from PC 0 with count cleared.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch/issue controller.
package fetch_ctrl_pkg;

   localparam int PC_W  = 16;
   localparam int OPC_W = 4;
   localparam int OPR_W = 3;
   localparam int IMM_W = 8;

   localparam logic [OPC_W-1:0] DEF_BR_OPCODE = 4'hB;
   localparam logic [8:0]       HALT_WORD     = 9'b111111111;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      ISSUE,
      BRANCH,
      HALT
   } state_t;

   typedef enum logic [1:0] {
      PC_HOLD,
      PC_CLEAR,
      PC_INC,
      PC_ADD
   } pc_op_t;

   typedef struct packed {
      logic             format;
      logic [OPC_W-1:0] opcode;
      logic             sign;
      logic [OPR_W-1:0] operand;
      logic [IMM_W-1:0] immediate;
   } ir_t;

   // Immediate field is irrelevant to halt detection
   function automatic logic is_halt(input ir_t w);
      return {w.format, w.opcode, w.sign, w.operand} == HALT_WORD;
   endfunction

endpackage

// File: rtl/fetch_ctrl_pc_unit.sv
// Program counter register with clear, increment and signed-offset add.
module pc_unit
   import fetch_ctrl_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  pc_op_t          op,
   input  logic [PC_W-1:0] offset,
   output logic [PC_W-1:0] pc
);

   logic [PC_W-1:0] pc_nxt;

   // Additions wrap naturally at the register width
   always_comb begin
      pc_nxt = pc;
      unique case (op)
         PC_CLEAR: pc_nxt = '0;
         PC_INC:   pc_nxt = pc + PC_W'(1);
         PC_ADD:   pc_nxt = pc + offset;
         default:  pc_nxt = pc;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) pc <= '0;
      else       pc <= pc_nxt;
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch/issue sequencer: fetches ROM words, issues them with a valid/ready
// handshake, resolves conditional branches and counts accepted instructions.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter logic [PC_W-1:0]  PROG_LEN  = 16'd42,
   parameter logic [OPC_W-1:0] BR_OPCODE = DEF_BR_OPCODE
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic [PC_W-1:0]  pc_in,
   input  logic             instr_format,
   input  logic [OPC_W-1:0] instr_opcode,
   input  logic             instr_sign,
   input  logic [OPR_W-1:0] instr_operand,
   input  logic [IMM_W-1:0] instr_immediate,
   output logic             ex_valid,
   input  logic             ex_ready,
   output logic             ex_format,
   output logic [OPC_W-1:0] ex_opcode,
   output logic             ex_sign,
   output logic [OPR_W-1:0] ex_operand,
   output logic [IMM_W-1:0] ex_immediate,
   input  logic             branch_flag,
   input  logic [PC_W-1:0]  br_offset,
   output logic             busy,
   output logic             halted,
   output logic [PC_W-1:0]  instr_count
);

   state_t state, state_nxt;
   ir_t    ir, rom;
   pc_op_t pc_op;
   logic   ir_load, cnt_clr, cnt_inc;
   logic   at_end, is_br, launch;

   assign rom    = {instr_format, instr_opcode, instr_sign,
                    instr_operand, instr_immediate};
   assign at_end = (pc_in == PROG_LEN);
   assign is_br  = ir.format && (ir.opcode == BR_OPCODE);
   assign launch = start && ((state == IDLE) || (state == HALT));

   pc_unit u_pc (
      .clk    (clk),
      .reset  (reset),
      .op     (pc_op),
      .offset (br_offset),
      .pc     (pc_in)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE, HALT: if (start) state_nxt = FETCH;
         FETCH:      state_nxt = (at_end || is_halt(rom)) ? HALT : ISSUE;
         ISSUE:      if (ex_ready) state_nxt = is_br ? BRANCH : FETCH;
         BRANCH:     state_nxt = FETCH;
         default:    state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ex_valid = (state == ISSUE);
      busy     = (state == FETCH) || (state == ISSUE) || (state == BRANCH);
      halted   = (state == HALT);
      ir_load  = (state == FETCH) && !at_end;
      cnt_clr  = launch;
      cnt_inc  = (state == ISSUE) && ex_ready;
      pc_op    = PC_HOLD;
      unique case (1'b1)
         launch:             pc_op = PC_CLEAR;
         cnt_inc && !is_br:  pc_op = PC_INC;
         state == BRANCH:    pc_op = branch_flag ? PC_ADD : PC_INC;
         default:            pc_op = PC_HOLD;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)        ir <= '0;
      else if (ir_load) ir <= rom;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)        instr_count <= '0;
      else if (cnt_clr) instr_count <= '0;
      else if (cnt_inc && (instr_count != '1))
         instr_count <= instr_count + PC_W'(1);
   end

   assign ex_format    = ir.format;
   assign ex_opcode    = ir.opcode;
   assign ex_sign      = ir.sign;
   assign ex_operand   = ir.operand;
   assign ex_immediate = ir.immediate;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed programs, issue monitor.
module tb_fetch_ctrl;

   typedef struct packed {
      logic [15:0] pc;
      logic [16:0] w;
   } exp_t;

   localparam logic [16:0] BR_W   = {1'b1, 4'hB, 1'b0, 3'd2, 8'h77};
   localparam logic [16:0] HALT_W = {9'h1FF, 8'h3C};
   localparam logic [16:0] W1_1   = {1'b0, 4'hB, 1'b1, 3'd5, 8'hC3};
   localparam logic [16:0] W1_2   = {1'b1, 4'h3, 1'b0, 3'd1, 8'h81};

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        start0 = 1'b0;
   logic        ex_ready = 1'b0;
   logic        branch_flag = 1'b0;
   logic [15:0] br_offset = 16'h0;
   int          test_id = 0;
   logic [16:0] rom_word;

   logic [15:0] pc_in, instr_count;
   logic        ex_valid, ex_format, ex_sign, busy, halted;
   logic [3:0]  ex_opcode;
   logic [2:0]  ex_operand;
   logic [7:0]  ex_immediate;

   logic [15:0] pc0, count0;
   logic        ex_valid0, ex_format0, ex_sign0, busy0, halted0;
   logic [3:0]  ex_opcode0;
   logic [2:0]  ex_operand0;
   logic [7:0]  ex_immediate0;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   cyc;

   always #5 clk = ~clk;

   function automatic logic [16:0] nop(input logic [15:0] a);
      return {1'b0, 4'h1, a[3], a[2:0], a[15:8] ^ a[7:0]};
   endfunction

   function automatic logic [16:0] rom_fn(input int id, input logic [15:0] a);
      logic [16:0] w;
      w = nop(a);
      case (id)
         1: begin
            if (a == 16'd1)      w = W1_1;
            else if (a == 16'd2) w = W1_2;
            else if (a == 16'd3) w = HALT_W;
         end
         2: if (a == 16'd1) w = HALT_W;
         3: begin
            if (a == 16'd10)      w = BR_W;
            else if (a == 16'd11) w = HALT_W;
         end
         4: begin
            if (a == 16'd0)      w = BR_W;
            else if (a == 16'd5) w = HALT_W;
         end
         5: if (a == 16'd2) w = HALT_W;
         default: ;
      endcase
      return w;
   endfunction

   assign rom_word = rom_fn(test_id, pc_in);

   fetch_ctrl dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .pc_in           (pc_in),
      .instr_format    (rom_word[16]),
      .instr_opcode    (rom_word[15:12]),
      .instr_sign      (rom_word[11]),
      .instr_operand   (rom_word[10:8]),
      .instr_immediate (rom_word[7:0]),
      .ex_valid        (ex_valid),
      .ex_ready        (ex_ready),
      .ex_format       (ex_format),
      .ex_opcode       (ex_opcode),
      .ex_sign         (ex_sign),
      .ex_operand      (ex_operand),
      .ex_immediate    (ex_immediate),
      .branch_flag     (branch_flag),
      .br_offset       (br_offset),
      .busy            (busy),
      .halted          (halted),
      .instr_count     (instr_count)
   );

   fetch_ctrl #(.PROG_LEN(16'd0)) dut0 (
      .clk             (clk),
      .reset           (reset),
      .start           (start0),
      .pc_in           (pc0),
      .instr_format    (1'b0),
      .instr_opcode    (4'h2),
      .instr_sign      (1'b0),
      .instr_operand   (3'd1),
      .instr_immediate (8'h55),
      .ex_valid        (ex_valid0),
      .ex_ready        (1'b1),
      .ex_format       (ex_format0),
      .ex_opcode       (ex_opcode0),
      .ex_sign         (ex_sign0),
      .ex_operand      (ex_operand0),
      .ex_immediate    (ex_immediate0),
      .branch_flag     (1'b0),
      .br_offset       (16'h0),
      .busy            (busy0),
      .halted          (halted0),
      .instr_count     (count0)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Issue monitor: every accepted instruction must match the queue head
   always @(negedge clk) begin
      exp_t e;
      logic [16:0] act;
      if (!reset && ex_valid && ex_ready) begin
         act = {ex_format, ex_opcode, ex_sign, ex_operand, ex_immediate};
         n_chk++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL issue_unexpected: got pc=%h word=%h want none",
                     pc_in, act);
         end else begin
            e = exp_q.pop_front();
            if (act !== e.w || pc_in !== e.pc) begin
               n_err++;
               $display("FAIL issue: got pc=%h word=%h want pc=%h word=%h",
                        pc_in, act, e.pc, e.w);
            end
         end
      end
   end

   task automatic push(input logic [15:0] a);
      exp_t e;
      e.pc = a;
      e.w  = rom_fn(test_id, a);
      exp_q.push_back(e);
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_halt(output int c);
      c = 0;
      do begin @(negedge clk); c++; end while (!halted && c < 300);
      chk("halt_timeout", {31'd0, halted}, 32'd1);
   endtask

   task automatic wait_hs(input logic [15:0] a);
      int n;
      n = 0;
      do begin
         @(negedge clk); n++;
      end while (!(ex_valid && ex_ready && pc_in == a) && n < 300);
      chk("hs_timeout", {31'd0, (ex_valid && ex_ready && pc_in == a)}, 32'd1);
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (!ex_valid && n < 300);
      chk("valid_timeout", {31'd0, ex_valid}, 32'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset and idle behaviour
      repeat (2) @(negedge clk);
      chk("in_reset", {pc_in, ex_valid, busy, halted}, 32'd0);
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_pc_cnt", {pc_in, instr_count}, 32'd0);
      chk("rst_flags", {29'd0, ex_valid, busy, halted}, 32'd0);
      chk("rst_ir", {15'd0, ex_format, ex_opcode, ex_sign, ex_operand,
                     ex_immediate}, 32'd0);
      repeat (4) @(negedge clk);
      chk("idle_wait", {15'd0, busy, pc_in}, 32'd0);

      // PROG_LEN=0: first fetch ends the program
      @(posedge clk); #1 start0 = 1'b1;
      @(posedge clk); #1 start0 = 1'b0;
      @(negedge clk);
      chk("len0_fetch", {30'd0, busy0, halted0}, 32'd2);
      @(negedge clk);
      chk("len0_halt", {14'd0, busy0, halted0, pc0}, {14'd0, 2'b01, 16'd0});
      chk("len0_out", {ex_valid0, count0, ex_format0, ex_opcode0, ex_sign0,
                       ex_operand0, ex_immediate0[3:0]}, 32'd0);

      // straight-line program with halt at 3
      test_id = 1;
      ex_ready = 1'b1;
      push(16'd0); push(16'd1); push(16'd2);
      pulse_start();
      wait_halt(cyc);
      chk("sl_cycles", cyc, 32'd8);
      chk("sl_pc", {16'd0, pc_in}, 32'd3);
      chk("sl_count", {16'd0, instr_count}, 32'd3);
      chk("sl_flags", {29'd0, ex_valid, busy, halted}, 32'd1);

      // backpressure, restart from HALT, start ignored in ISSUE
      test_id = 2;
      ex_ready = 1'b0;
      pulse_start();
      wait_valid();
      chk("bp_cnt_clr", {16'd0, instr_count}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1 start = (i == 2);
         @(negedge clk);
         chk("bp_hold", {ex_valid, pc_in, ex_format, ex_opcode, ex_sign,
                         ex_operand, ex_immediate[3:0]},
             {1'b1, 16'd0, nop(16'd0)} >> 4);
         chk("bp_cnt", {16'd0, instr_count}, 32'd0);
      end
      push(16'd0);
      @(posedge clk); #1 start = 1'b0; ex_ready = 1'b1;
      wait_halt(cyc);
      chk("bp_count", {16'd0, instr_count}, 32'd1);
      chk("bp_pc", {16'd0, pc_in}, 32'd1);

      // branch at 10: taken to 5, then not taken to 11
      test_id = 3;
      branch_flag = 1'b1;
      br_offset = 16'hFFFB;
      for (int a = 0; a <= 10; a++) push(16'(a));
      for (int a = 5; a <= 10; a++) push(16'(a));
      pulse_start();
      wait_hs(16'd10);
      @(posedge clk); @(negedge clk);
      chk("br_state", {14'd0, busy, ex_valid, pc_in}, {14'd0, 2'b10, 16'd10});
      @(posedge clk); #1 branch_flag = 1'b0;
      @(negedge clk);
      chk("br_taken_pc", {16'd0, pc_in}, 32'd5);
      wait_hs(16'd10);
      @(posedge clk); @(posedge clk); @(negedge clk);
      chk("br_not_taken_pc", {16'd0, pc_in}, 32'd11);
      wait_halt(cyc);
      chk("br_count", {16'd0, instr_count}, 32'd17);

      // wrap: branch 0 -> FFFF, FFFF + 1 -> 0, then branch to halt at 5
      test_id = 4;
      branch_flag = 1'b1;
      br_offset = 16'hFFFF;
      push(16'd0); push(16'hFFFF); push(16'd0);
      pulse_start();
      wait_hs(16'd0);
      @(posedge clk); @(negedge clk);
      chk("wr_br_state", {16'd0, pc_in}, 32'd0);
      @(posedge clk); #1 br_offset = 16'd5;
      @(negedge clk);
      chk("wr_pc_ffff", {16'd0, pc_in}, 32'h0000FFFF);
      wait_hs(16'hFFFF);
      @(posedge clk); @(negedge clk);
      chk("wr_pc_0", {15'd0, busy, pc_in}, 32'h00010000);
      wait_halt(cyc);
      chk("wr_end", {instr_count, pc_in}, {16'd3, 16'd5});

      // reset mid-handshake, then restart
      test_id = 5;
      branch_flag = 1'b0;
      ex_ready = 1'b1;
      push(16'd0);
      pulse_start();
      wait_hs(16'd0);
      @(posedge clk); #1 ex_ready = 1'b0;
      wait_valid();
      chk("rs_pre", {instr_count, pc_in}, {16'd1, 16'd1});
      @(posedge clk); #2 reset = 1'b1;
      #1;
      chk("rs_async_flags", {29'd0, ex_valid, busy, halted}, 32'd0);
      chk("rs_async_pc", {instr_count, pc_in}, 32'd0);
      chk("rs_async_ir", {15'd0, ex_format, ex_opcode, ex_sign, ex_operand,
                          ex_immediate}, 32'd0);
      @(posedge clk); @(posedge clk); #1 reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rs_idle", {15'd0, busy, pc_in}, 32'd0);
      ex_ready = 1'b1;
      push(16'd0); push(16'd1);
      pulse_start();
      wait_halt(cyc);
      chk("rs_cycles", cyc, 32'd6);
      chk("rs_end", {instr_count, pc_in}, {16'd2, 16'd2});

      repeat (2) @(negedge clk);
      chk("sb_empty", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
